// File: rtl/soin_bpredictor_update_ctrl_pkg.sv
// Shared definitions for the gselect direction-table write-port controller:
// metadata field layout and controller state encodings.
package soin_bpredictor_update_ctrl_pkg;

  localparam int BP_META_WIDTH = 18;

  localparam int META_IDX_LSB = 0;
  localparam int META_IDX_MSB = 11;
  localparam int META_CTR_LSB = 12;
  localparam int META_CTR_MSB = 13;
  localparam int META_RAS_LSB = 14;
  localparam int META_RAS_MSB = 17;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/soin_bpredictor_update_fifo.sv
// Small synchronous FIFO holding pending predictor updates.
// Accepts a push and a pop together even when full.
module soin_bpredictor_update_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_headData,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wrPtr;
  logic [PTR_W:0]   r_rdPtr;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign o_empty    = (r_wrPtr == r_rdPtr);
  assign o_full     = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                      (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
  assign o_headData = r_mem[r_rdPtr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (i_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wrPtr[PTR_W-1:0]] <= i_pushData;
  end

endmodule

// File: rtl/soin_bpredictor_update_ctrl.sv
// Write-port controller for the gselect direction table: initial sweep,
// queued saturating-counter updates and debug preload arbitration.
module soin_bpredictor_update_ctrl
  import soin_bpredictor_update_ctrl_pkg::*;
#(
  parameter int               INDEX_W    = 12,
  parameter int               CTR_W      = 2,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [CTR_W-1:0] INIT_VALUE = 2'b01
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     soin_bpredictor_flush,
  input  logic                     execute_bpredictor_update,
  input  logic                     execute_bpredictor_dir,
  input  logic [BP_META_WIDTH-1:0] execute_bpredictor_meta,
  input  logic                     soin_bpredictor_dbg_wen,
  input  logic [INDEX_W-1:0]       soin_bpredictor_dbg_index,
  input  logic [CTR_W-1:0]         soin_bpredictor_dbg_data,
  output logic [INDEX_W-1:0]       ctrl_mem_wraddress,
  output logic [CTR_W-1:0]         ctrl_mem_data,
  output logic                     ctrl_mem_wren,
  output logic                     ctrl_bpredictor_stall,
  output logic [7:0]               ctrl_drop_count
);

  localparam int                 ENTRY_W    = INDEX_W + CTR_W + 1;
  localparam logic [INDEX_W-1:0] LAST_INDEX = '1;
  localparam logic [INDEX_W-1:0] INDEX_ONE  = {{(INDEX_W-1){1'b0}}, 1'b1};
  localparam logic [CTR_W-1:0]   CTR_MAX    = '1;
  localparam logic [CTR_W-1:0]   CTR_ONE    = {{(CTR_W-1){1'b0}}, 1'b1};

  ctrl_state_t        r_state;
  ctrl_state_t        w_nextState;
  logic [INDEX_W-1:0] r_sweepPtr;
  logic [INDEX_W-1:0] r_wrAddress;
  logic [CTR_W-1:0]   r_wrData;
  logic               r_wrEn;
  logic               r_stall;
  logic [7:0]         r_dropCount;

  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_pushEntry;
  logic [ENTRY_W-1:0] w_headEntry;
  logic [INDEX_W-1:0] w_headIndex;
  logic [CTR_W-1:0]   w_headCtr;
  logic               w_headDir;
  logic [CTR_W-1:0]   w_newCtr;
  logic               w_unusedMeta;

  assign w_pushEntry = {execute_bpredictor_meta[INDEX_W-1:0],
                        execute_bpredictor_meta[META_CTR_LSB +: CTR_W],
                        execute_bpredictor_dir};
  assign {w_headIndex, w_headCtr, w_headDir} = w_headEntry;
  assign w_unusedMeta = ^execute_bpredictor_meta[BP_META_WIDTH-1:META_CTR_LSB+CTR_W];

  soin_bpredictor_update_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (soin_bpredictor_flush),
    .i_push     (w_push),
    .i_pushData (w_pushEntry),
    .i_pop      (w_pop),
    .o_headData (w_headEntry),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Debug writes own the port; a queued update only pops when it is free.
  // A full queue still accepts a push when the head leaves the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_INIT: begin
        if (!soin_bpredictor_flush && (r_sweepPtr == LAST_INDEX)) w_nextState = S_RUN;
      end
      S_RUN: begin
        if (soin_bpredictor_flush) begin
          w_nextState = S_INIT;
        end else begin
          w_pop  = !soin_bpredictor_dbg_wen && !w_empty;
          w_push = execute_bpredictor_update && (!w_full || w_pop);
          w_drop = execute_bpredictor_update && w_full && !w_pop;
        end
      end
      default: w_nextState = S_INIT;
    endcase
  end

  always_comb begin
    w_newCtr = w_headCtr;
    if (w_headDir) begin
      if (w_headCtr != CTR_MAX) w_newCtr = w_headCtr + CTR_ONE;
    end else begin
      if (w_headCtr != '0) w_newCtr = w_headCtr - CTR_ONE;
    end
  end

  // Stall is registered from the current state, so it drops one cycle after the last sweep write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_sweepPtr  <= '0;
      r_wrAddress <= '0;
      r_wrData    <= '0;
      r_wrEn      <= 1'b0;
      r_stall     <= 1'b1;
      r_dropCount <= '0;
    end else begin
      r_state <= w_nextState;
      r_stall <= (r_state == S_INIT) | w_full;
      r_wrEn  <= 1'b0;
      if (soin_bpredictor_flush) begin
        r_sweepPtr <= '0;
      end else if (r_state == S_INIT) begin
        r_wrEn      <= 1'b1;
        r_wrAddress <= r_sweepPtr;
        r_wrData    <= INIT_VALUE;
        r_sweepPtr  <= r_sweepPtr + INDEX_ONE;
      end else if (soin_bpredictor_dbg_wen) begin
        r_wrEn      <= 1'b1;
        r_wrAddress <= soin_bpredictor_dbg_index;
        r_wrData    <= soin_bpredictor_dbg_data;
      end else if (w_pop) begin
        r_wrEn      <= 1'b1;
        r_wrAddress <= w_headIndex;
        r_wrData    <= w_newCtr;
      end
      if (w_drop && (r_dropCount != 8'hFF)) r_dropCount <= r_dropCount + 8'd1;
    end
  end

  assign ctrl_mem_wraddress    = r_wrAddress;
  assign ctrl_mem_data         = r_wrData;
  assign ctrl_mem_wren         = r_wrEn;
  assign ctrl_bpredictor_stall = r_stall;
  assign ctrl_drop_count       = r_dropCount;

endmodule
